// File: rtl/udp_tx_fifo_ctrl.sv
// udp_tx_fifo_ctrl: packet sequencer around the 8-bit sync UDP TX FIFO
// Ports: in_* byte stream from packetiser; fifo_* FIFO write/read control;
//        tx_req/tx_len/tx_ack packet offer to the UDP engine; out_* byte stream out;
//        trunc_err pulses on an oversize packet; pkt_cnt counts packets fully streamed.
// Optional: define UDP_TX_PAD_EN to pad short packets with 0x00 bytes up to MIN_LEN.
module udp_tx_fifo_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT = 2,
  parameter int MAX_PKT = 96,
  parameter int LQ_DEPTH = 4,
  parameter int MIN_LEN = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_wr_en,
  input  logic        fifo_almost_full,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        tx_req,
  output logic [15:0] tx_len,
  input  logic        tx_ack,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        trunc_err,
  output logic [15:0] pkt_cnt
);
  localparam int SK = RD_LAT + 2;
  localparam int SW = $clog2(SK);
  localparam int CW = $clog2(SK + 1);
  localparam int LW = $clog2(LQ_DEPTH);
  localparam int QW = LW + 1;
  localparam logic [15:0] MAXL = 16'(MAX_PKT);
`ifdef UDP_TX_PAD_EN
  localparam logic [15:0] MINL = 16'(MIN_LEN);
`endif

  if (MAX_PKT >= 2 ** ADDR_WIDTH || MIN_LEN > 65535 || RD_LAT < 1) begin : g_param_check
    $error("udp_tx_fifo_ctrl: invalid parameters");
  end

  typedef enum logic {ACCEPT, DISCARD} wstate_t;
  typedef enum logic [1:0] {IDLE, OFFER, STREAM, DRAIN} rstate_t;

  wstate_t ws, ws_nx;
  rstate_t rs, rs_nx;
  logic live;
  logic [15:0] wcnt;
  logic [15:0] lq [LQ_DEPTH];
  logic [LW:0] lq_wp, lq_rp;
  logic lq_full, lq_empty;
  logic acc, at_max, push, trunc, pop;
  logic [15:0] head, head_len, rem, sent, total;
  logic [RD_LAT-1:0] pipe;
  logic [CW-1:0] outst, sk_cnt;
  logic [7:0] sk [SK];
  logic [SW-1:0] sk_wp, sk_rp;
  logic cap, want, pad, hs, sk_pop, done;

  assign lq_empty = lq_wp == lq_rp;
  assign lq_full = lq_wp[LW] != lq_rp[LW] && lq_wp[LW-1:0] == lq_rp[LW-1:0];

  // live holds in_ready low during and for the first edge after reset
  always_comb begin
    in_ready = live && (ws == DISCARD || (!fifo_almost_full && !lq_full));
    acc = in_valid && in_ready;
    fifo_wr_en = acc && ws == ACCEPT;
    fifo_wr_data = fifo_wr_en ? in_data : 8'h00;
    at_max = wcnt == MAXL - 16'd1;
    push = fifo_wr_en && (in_last || at_max);
    trunc = fifo_wr_en && at_max && !in_last;
    ws_nx = trunc ? DISCARD : (ws == DISCARD && acc && in_last) ? ACCEPT : ws;
  end

  always_comb begin
    head = lq[lq_rp[LW-1:0]];
`ifdef UDP_TX_PAD_EN
    head_len = head < MINL ? MINL : head;
`else
    head_len = head;
`endif
    tx_req = rs == OFFER;
    tx_len = tx_req ? head_len : 16'd0;
    pop = tx_req && tx_ack;
    cap = pipe[RD_LAT-1];
    // in-flight reads reserve skid slots so a capture always has room
    want = rs == STREAM && rem != 16'd0 && (outst + sk_cnt) < CW'(SK);
    fifo_rd_en = want && !fifo_empty;
`ifdef UDP_TX_PAD_EN
    // pad only once every real byte has left the skid
    pad = (rs == STREAM || rs == DRAIN) && rem == 16'd0 && outst == '0 && sk_cnt == '0 && sent < total;
`else
    pad = 1'b0;
`endif
    out_valid = sk_cnt != '0 || pad;
    out_data = sk_cnt != '0 ? sk[sk_rp] : 8'h00;
    out_last = out_valid && sent == total - 16'd1;
    hs = out_valid && out_ready;
    sk_pop = hs && sk_cnt != '0;
    done = hs && out_last;
    rs_nx = rs == IDLE ? (lq_empty ? IDLE : OFFER)
          : rs == OFFER ? (tx_ack ? STREAM : OFFER)
          : done ? IDLE
          : (rs == STREAM && rem == 16'd0) ? DRAIN : rs;
  end

  always_ff @(posedge clk) begin
    if (push) lq[lq_wp[LW-1:0]] <= wcnt + 16'd1;
    if (cap) sk[sk_wp] <= fifo_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      ws <= ACCEPT;
      wcnt <= '0;
      trunc_err <= 1'b0;
      lq_wp <= '0;
      lq_rp <= '0;
      rs <= IDLE;
      rem <= '0;
      sent <= '0;
      total <= '0;
      pipe <= '0;
      outst <= '0;
      sk_cnt <= '0;
      sk_wp <= '0;
      sk_rp <= '0;
      pkt_cnt <= '0;
    end else begin
      live <= 1'b1;
      ws <= ws_nx;
      trunc_err <= trunc;
      wcnt <= push ? 16'd0 : wcnt + 16'(fifo_wr_en);
      lq_wp <= lq_wp + QW'(push);
      lq_rp <= lq_rp + QW'(pop);
      rs <= rs_nx;
      rem <= pop ? head : rem - 16'(fifo_rd_en);
      total <= pop ? head_len : total;
      sent <= pop ? 16'd0 : sent + 16'(hs);
      pipe <= RD_LAT'({pipe, fifo_rd_en});
      outst <= outst + CW'(fifo_rd_en) - CW'(cap);
      sk_cnt <= sk_cnt + CW'(cap) - CW'(sk_pop);
      sk_wp <= cap ? (sk_wp == SW'(SK - 1) ? '0 : sk_wp + 1'b1) : sk_wp;
      sk_rp <= sk_pop ? (sk_rp == SW'(SK - 1) ? '0 : sk_rp + 1'b1) : sk_rp;
      pkt_cnt <= pkt_cnt + 16'(done);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst_n && want && fifo_empty) $error("udp_tx_fifo_ctrl: read held with FIFO empty");
`endif
endmodule

// File: tb/tb_udp_tx_fifo_ctrl.sv
// tb_udp_tx_fifo_ctrl: directed bench with a behavioural 128-byte FIFO (2-cycle read latency)
module tb_udp_tx_fifo_ctrl;
  localparam int MAXP = 96;
`ifdef UDP_TX_PAD_EN
  localparam int L1 = 18, L4 = 18, L6 = 18;
`else
  localparam int L1 = 1, L4 = 4, L6 = 6;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [7:0] fifo_wr_data, fifo_rd_data;
  logic fifo_wr_en, fifo_almost_full, fifo_rd_en, fifo_empty;
  logic tx_req, tx_ack = 1'b0;
  logic [15:0] tx_len, pkt_cnt;
  logic [7:0] out_data;
  logic out_valid, out_last, out_ready = 1'b0, trunc_err;
  logic af_force = 1'b0;
  int checks = 0, failures = 0, trunc_seen = 0, rd_empty_seen = 0, exp_pkts = 0;

  always #5 clk = ~clk;

  udp_tx_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_almost_full(fifo_almost_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
  );

  logic [7:0] fmem [128];
  logic [6:0] fwp, frp;
  logic [7:0] fs1;
  int fcnt;
  assign fifo_empty = fcnt == 0;
  assign fifo_almost_full = af_force || fcnt >= 120;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fwp <= '0; frp <= '0; fcnt <= 0; fs1 <= '0; fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en) begin fmem[fwp] <= fifo_wr_data; fwp <= fwp + 7'd1; end
      if (fifo_rd_en) begin fs1 <= fmem[frp]; frp <= frp + 7'd1; end
      fifo_rd_data <= fs1;
      fcnt <= fcnt + int'(fifo_wr_en) - int'(fifo_rd_en);
    end

  always @(posedge clk) begin
    if (rst_n && fifo_rd_en && fifo_empty) rd_empty_seen <= rd_empty_seen + 1;
    if (rst_n && trunc_err) trunc_seen <= trunc_seen + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [7:0] base, input int len);
    int i = 0, t = 0;
    while (i < len && t < 3000) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = base + 8'(i); in_last = i == len - 1;
      #1;
      if (in_ready) begin
        chk("wr_pass", {fifo_wr_en, fifo_wr_data}, i < MAXP ? {1'b1, base + 8'(i)} : 9'h000);
        i++;
      end
      t++;
    end
    chk("send_done", i, len);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic recv_pkt(input logic [7:0] base, input int real_n, input int explen, input int mode, input int stop);
    int t = 0, n = 0, c = 0;
    logic stall = 1'b0;
    logic [9:0] held = '0;
    @(negedge clk);
    while (!tx_req && t < 2000) begin @(negedge clk); t++; end
    chk("tx_req", tx_req, 1);
    chk("tx_len", tx_len, explen);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("tx_req_drop", tx_req, 0);
    t = 0;
    while (n < stop && t < 4000) begin
      out_ready = mode == 0 || c % 3 == 0;
      c++;
      #1;
      if (stall) chk("hold", {out_valid, out_last, out_data}, held);
      if (out_valid && out_ready) begin
        chk("data", out_data, n < real_n ? base + 8'(n) : 8'h00);
        chk("last", out_last, n == explen - 1);
        n++;
      end
      stall = out_valid && !out_ready;
      held = {1'b1, out_last, out_data};
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    chk("recv_count", n, stop);
  endtask

  typedef struct {
    logic af; logic v; logic [7:0] d;
    logic exp_ready; logic exp_wr; logic [7:0] exp_wd;
  } wvec_t;
  typedef struct {
    int len; logic [7:0] base; int mode; int exp_len; int exp_trunc;
  } pvec_t;

  wvec_t wv [4];
  pvec_t pv [7];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t0;
    wv[0] = '{1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 8'h00};
    wv[1] = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00};
    wv[2] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00};
    wv[3] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00};
    pv[0] = '{10, 8'h01, 0, 10, 0};
    pv[1] = '{64, 8'h40, 1, 64, 0};
    pv[2] = '{120, 8'h80, 0, 96, 1};
    pv[3] = '{8, 8'hC0, 0, 8, 0};
    pv[4] = '{96, 8'h10, 1, 96, 0};
    pv[5] = '{1, 8'hEE, 0, L1, 0};
    pv[6] = '{6, 8'h21, 1, L6, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {in_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, tx_req, tx_len,
                          out_data, out_valid, out_last, trunc_err, pkt_cnt}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (wv[k]) begin
      @(negedge clk);
      af_force = wv[k].af; in_valid = wv[k].v; in_data = wv[k].d; in_last = 1'b0;
      #1;
      chk("wr_comb", {in_ready, fifo_wr_en, fifo_wr_data}, {wv[k].exp_ready, wv[k].exp_wr, wv[k].exp_wd});
    end
    @(negedge clk);
    af_force = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    foreach (pv[k]) begin
      t0 = trunc_seen;
      send_pkt(pv[k].base, pv[k].len);
      recv_pkt(pv[k].base, pv[k].len > MAXP ? MAXP : pv[k].len, pv[k].exp_len, pv[k].mode, pv[k].exp_len);
      exp_pkts++;
      repeat (3) @(negedge clk);
      chk("trunc_cnt", trunc_seen - t0, pv[k].exp_trunc);
      chk("pkt_cnt", pkt_cnt, exp_pkts);
    end

    fork
      for (int p = 0; p < 5; p++) send_pkt(8'(p * 32), 20);
      begin
        repeat (120) @(negedge clk);
        #2;
        chk("b2b_stall_ready", in_ready, 0);
        chk("b2b_stall_valid", in_valid, 1);
        chk("b2b_offer", {tx_req, tx_len}, {1'b1, 16'd20});
        for (int p = 0; p < 5; p++) begin
          recv_pkt(8'(p * 32), 20, 20, 0, 20);
          exp_pkts++;
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("b2b_pkt_cnt", pkt_cnt, exp_pkts);

    send_pkt(8'h50, 50);
    recv_pkt(8'h50, 50, 50, 0, 30);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {in_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, tx_req, tx_len,
                             out_data, out_valid, out_last, trunc_err, pkt_cnt}, 64'h0);
    exp_pkts = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_pkt(8'hA0, 4);
    recv_pkt(8'hA0, 4, L4, 0, L4);
    exp_pkts++;
    repeat (3) @(negedge clk);
    chk("post_reset_pkt_cnt", pkt_cnt, exp_pkts);
    chk("rd_on_empty", rd_empty_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/udp_tx_fifo_ctrl.md
Name: udp_tx_fifo_ctrl

Overview:
- Packet-level sequencer around the 8-bit sync UDP TX FIFO (depth 2**ADDR_WIDTH); sits between the video packetiser and the UDP TX engine.
- Write side: accepts a byte stream and writes it into the FIFO.
- Read side: announces each complete packet to the UDP engine with a length, then streams exactly that many bytes out.
- Owns the FIFO's wr_en/rd_en, absorbs its read latency, and truncates oversize packets.

Parameters:
- ADDR_WIDTH, 7: FIFO address width; FIFO depth = 2**ADDR_WIDTH.
- RD_LAT, 2: FIFO rd_en-to-rd_data latency in cycles (2 with output register).
- MAX_PKT, 96: maximum payload bytes per packet; must be < 2**ADDR_WIDTH.
- LQ_DEPTH, 4: length-queue entries (power of 2).
- MIN_LEN, 18: minimum output length; used only with UDP_TX_PAD_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  in_data valid
- in_last  in  1  last byte of packet
- in_ready  out  1  byte accepted when in_valid && in_ready
- fifo_wr_data  out  8  to FIFO wr_data
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_almost_full  in  1  from FIFO
- fifo_rd_en  out  1  to FIFO rd_en
- fifo_rd_data  in  8  from FIFO rd_data
- fifo_empty  in  1  from FIFO
- tx_req  out  1  packet available, held until tx_ack
- tx_len  out  16  byte count of the offered packet; stable while tx_req
- tx_ack  in  1  single-cycle acceptance by the UDP engine
- out_data  out  8  streamed byte
- out_valid  out  1  out_data valid
- out_last  out  1  final byte of packet
- out_ready  in  1  engine consumes when out_valid && out_ready
- trunc_err  out  1  one-cycle pulse when a packet is truncated
- pkt_cnt  out  16  packets fully streamed, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0, all counters 0, length queue empty, both FSMs in IDLE/ACCEPT. Reset mid-packet discards all state; the FIFO must be reset by the same event.
- Write FSM states: ACCEPT, DISCARD.
  - ACCEPT: in_ready = !fifo_almost_full && !lq_full.
  - Each accepted byte gives fifo_wr_en=1 and fifo_wr_data=in_data in the same cycle (combinational pass-through), and increments wcnt.
  - On an accepted in_last, or when wcnt reaches MAX_PKT: push the length (wcnt+1) into the length queue and clear wcnt.
  - If MAX_PKT is reached without in_last: pulse trunc_err and go to DISCARD.
  - DISCARD: in_ready=1, no FIFO writes, bytes dropped. An accepted in_last returns the FSM to ACCEPT.
- Length queue:
  - Push and pop in the same cycle are both honoured.
  - lq_full blocks acceptance of any byte, including mid-packet bytes.
- Read FSM states: IDLE, OFFER, STREAM, DRAIN.
  - IDLE: when the length queue is non-empty, go to OFFER next cycle; tx_len = head entry.
  - OFFER: tx_req=1; on tx_ack, pop the queue, load rem=tx_len, go to STREAM.
  - STREAM: fifo_rd_en=1 when rem>0 && (outstanding + skid occupancy) < RD_LAT+2. Each rd_en decrements rem and schedules a capture of fifo_rd_data RD_LAT cycles later into a skid buffer of depth RD_LAT+2.
  - out_valid = skid non-empty. out_last is set on the byte that brings the sent count to tx_len.
  - When rem reaches 0, go to DRAIN.
  - DRAIN: continue streaming. After the last handshake, increment pkt_cnt and return to IDLE. Minimum 1 idle cycle between packets (no tx_req in that cycle).
- fifo_rd_en must never assert with fifo_empty=1; if it would, hold the read and flag it in simulation only via $error.
- out_ready low stalls output indefinitely; no byte is lost or duplicated. out_data and out_last must hold while out_valid && !out_ready.
- Simultaneous write and read of the FIFO are permitted. Write-side backpressure never stalls the read side.
- MAX_PKT < depth guarantees any queued packet fits, so no deadlock.

Optional Feature:
- Macro: UDP_TX_PAD_EN.
- Defined:
  - tx_len = max(len, MIN_LEN).
  - After the last real byte, the controller emits 0x00 pad bytes to reach MIN_LEN, with out_last on the final pad byte.
  - Pad bytes perform no FIFO reads.
- Undefined: tx_len = len exactly; no padding logic is synthesised.

Test Plan:
- Single packet: 10 bytes 0x01..0x0A, in_last on 0x0A, out_ready=1 -> tx_req with tx_len=10; after tx_ack, out_data 0x01..0x0A with out_last on 0x0A; pkt_cnt=1.
- Back-to-back: 5 packets of 20 bytes written continuously -> the 5th packet stalls (in_ready=0) while lq holds 4 packets; after the first packet drains, all 5 stream in order; pkt_cnt=5.
- Backpressure: 64-byte packet, out_ready toggling 1,0,0,1,... -> output sequence intact, no fifo_rd_en while fifo_empty, skid never overflows.
- Truncation: 120-byte packet with MAX_PKT=96 -> trunc_err pulses once, tx_len=96, 24 bytes dropped; the next 8-byte packet streams correctly.
- Reset mid-stream: rst_n low at byte 30 of 50 -> all outputs 0 immediately; a post-reset packet of 4 bytes streams with tx_len=4.
- UDP_TX_PAD_EN with a 6-byte packet -> tx_len=18; 6 data bytes, then 12 bytes of 0x00, out_last on byte 18.
